// File: rtl/xunit_msg_sched.sv
// SHA-256 message-schedule xunit: loads W0..W15 and streams W0..W63 on out0.
// Optional K-constant stream on out1 when XUNITM_KCONST_EN is defined.
module xunit_msg_sched #(
   parameter int DELAY_W = 7,
   parameter int DATA_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               running,
   input  logic               run,
   output logic               done,
   input  logic [DATA_W-1:0]  in0,
   input  logic [DATA_W-1:0]  in1,
   input  logic [DATA_W-1:0]  in2,
   input  logic [DATA_W-1:0]  in3,
   input  logic [DATA_W-1:0]  in4,
   input  logic [DATA_W-1:0]  in5,
   input  logic [DATA_W-1:0]  in6,
   input  logic [DATA_W-1:0]  in7,
   input  logic [DATA_W-1:0]  in8,
   input  logic [DATA_W-1:0]  in9,
   input  logic [DATA_W-1:0]  in10,
   input  logic [DATA_W-1:0]  in11,
   input  logic [DATA_W-1:0]  in12,
   input  logic [DATA_W-1:0]  in13,
   input  logic [DATA_W-1:0]  in14,
   input  logic [DATA_W-1:0]  in15,
   output logic [DATA_W-1:0]  out0,
   output logic [DATA_W-1:0]  out1,
   input  logic [DELAY_W-1:0] delay0
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM, S_HOLD} state_t;

   state_t             state_q, state_d;
   logic [DELAY_W-1:0] delay_q, delay_d;
   logic [5:0]         cnt_q, cnt_d;
   logic [DATA_W-1:0]  win_q [16];
   logic [DATA_W-1:0]  win_d [16];
   logic [DATA_W-1:0]  in_w  [16];
   logic               load, step;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   assign in_w = '{in0, in1, in2, in3, in4, in5, in6, in7,
                   in8, in9, in10, in11, in12, in13, in14, in15};

   // run overrides everything; otherwise nothing moves unless running is high
   assign load = !run && running && (state_q == S_WAIT) && (delay_q == '0);
   assign step = !run && running && (state_q == S_STREAM);

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path infers a latch.
      state_d = state_q;
      delay_d = delay_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
      if (run) begin
         delay_d = delay0;
         cnt_d   = '0;
         state_d = S_WAIT;
      end else if (running) begin
         case (state_q)
            S_WAIT: begin
               if (delay_q != '0) begin
                  delay_d = delay_q - 1'b1;
               end else begin
                  win_d   = in_w;
                  cnt_d   = '0;
                  state_d = S_STREAM;
               end
            end
            S_STREAM: begin
               for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
               win_d[15] = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
               cnt_d     = cnt_q + 6'd1;
               if (cnt_q == 6'd62) state_d = S_HOLD;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         delay_q <= '0;
         cnt_q   <= '0;
         // NOTE: the window is reset because out0 reads it directly and must show 0 after rst.
         win_q   <= '{default: '0};
      end else begin
         // NOTE: non-blocking assignments keep the window shift order-independent.
         state_q <= state_d;
         delay_q <= delay_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
      end
   end

   assign out0 = win_q[0];
   assign done = (state_q == S_IDLE) || (state_q == S_HOLD);

`ifdef XUNITM_KCONST_EN
   localparam logic [0:63][31:0] K_ROM = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic [DATA_W-1:0] k_q, k_d;

   // K tracks cnt_d so it lands on the same edge as the matching W word
   always_comb begin
      k_d = k_q;
      if (load || step) k_d = K_ROM[cnt_d];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) k_q <= '0;
      else     k_q <= k_d;
   end

   assign out1 = k_q;
`else
   assign out1 = '0;
`endif

endmodule

// File: tb/tb_xunit_msg_sched.sv
// Directed bench for xunit_msg_sched: "abc" block, delays, running gaps, re-run and mid-stream reset.
module tb_xunit_msg_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        running = 1'b0;
   logic        run = 1'b0;
   logic        done;
   logic [6:0]  delay0 = '0;
   logic [31:0] out0, out1;
   logic [31:0] blk   [16];
   logic [31:0] w_exp [64];

   int n_total = 0;
   int n_pass  = 0;

   xunit_msg_sched #(.DELAY_W(7), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .running(running), .run(run), .done(done),
      .in0(blk[0]),   .in1(blk[1]),   .in2(blk[2]),   .in3(blk[3]),
      .in4(blk[4]),   .in5(blk[5]),   .in6(blk[6]),   .in7(blk[7]),
      .in8(blk[8]),   .in9(blk[9]),   .in10(blk[10]), .in11(blk[11]),
      .in12(blk[12]), .in13(blk[13]), .in14(blk[14]), .in15(blk[15]),
      .out0(out0), .out1(out1), .delay0(delay0)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic build_model();
      logic [31:0] s0, s1;
      for (int t = 0; t < 16; t++) w_exp[t] = blk[t];
      for (int t = 16; t < 64; t++) begin
         s0 = rotr(w_exp[t-15], 7) ^ rotr(w_exp[t-15], 18) ^ (w_exp[t-15] >> 3);
         s1 = rotr(w_exp[t-2], 17) ^ rotr(w_exp[t-2], 19) ^ (w_exp[t-2] >> 10);
         w_exp[t] = s1 + w_exp[t-7] + s0 + w_exp[t-16];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_block(input logic [31:0] seed);
      for (int i = 0; i < 16; i++) blk[i] = (seed * (i + 1)) ^ {16'hA5C3, 8'(i), 8'h5A};
      build_model();
   endtask

   // pulse run for one edge and confirm done drops on the following cycle
   task automatic do_run(input logic [6:0] d);
      delay0 = d;
      run = 1'b1;
      tick();
      run = 1'b0;
      n_total++;
      if (done !== 1'b0) $display("FAIL done_after_run: got %b expected 0", done);
      else n_pass++;
   endtask

   task automatic expect_range(input int from, input int to, input bit abc);
      logic [31:0] exp_k;
      for (int t = from; t <= to; t++) begin
         tick();
         n_total++;
         if (out0 !== w_exp[t]) $display("FAIL out0 t=%0d: got %h expected %h", t, out0, w_exp[t]);
         else n_pass++;
         n_total++;
         if (done !== (t == 63)) $display("FAIL done t=%0d: got %b expected %b", t, done, (t == 63));
         else n_pass++;
         if (abc && t == 16) begin
            n_total++;
            if (out0 !== 32'h61626380) $display("FAIL abc_w16: got %h expected 61626380", out0);
            else n_pass++;
         end
         if (abc && t == 17) begin
            n_total++;
            if (out0 !== 32'h000F0000) $display("FAIL abc_w17: got %h expected 000f0000", out0);
            else n_pass++;
         end
         if (t == 0 || t == 63) begin
`ifdef XUNITM_KCONST_EN
            exp_k = (t == 0) ? 32'h428A2F98 : 32'hC67178F2;
`else
            exp_k = 32'h0;
`endif
            n_total++;
            if (out1 !== exp_k) $display("FAIL out1 t=%0d: got %h expected %h", t, out1, exp_k);
            else n_pass++;
         end
      end
   endtask

   task automatic expect_hold(input int cycles, input logic [31:0] w63);
      for (int i = 0; i < cycles; i++) begin
         tick();
         n_total++;
         if (out0 !== w63 || done !== 1'b1)
            $display("FAIL hold: got out0=%h done=%b expected out0=%h done=1", out0, done, w63);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      n_total++;
      if (out0 !== 32'h0 || out1 !== 32'h0 || done !== 1'b1)
         $display("FAIL reset: got out0=%h out1=%h done=%b expected 0/0/1", out0, out1, done);
      else n_pass++;
   endtask

   task automatic test_abc();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
      build_model();
      running = 1'b1;
      do_run(7'd0);
      expect_range(0, 63, 1'b1);
      expect_hold(3, w_exp[63]);
   endtask

   // delay0=5 from HOLD: five countdown cycles, sample on the sixth edge
   task automatic test_delay();
      logic [31:0] old_w63;
      old_w63 = w_exp[63];
      set_block(32'h9E3779B9);
      do_run(7'd5);
      for (int i = 0; i < 5; i++) begin
         tick();
         n_total++;
         if (out0 !== old_w63 || done !== 1'b0)
            $display("FAIL delay_wait i=%0d: got out0=%h done=%b expected out0=%h done=0", i, out0, done, old_w63);
         else n_pass++;
      end
      expect_range(0, 63, 1'b0);
   endtask

   task automatic test_wait_pause();
      logic [31:0] old_w63;
      old_w63 = w_exp[63];
      set_block(32'h3C6EF372);
      do_run(7'd2);
      running = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      running = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_total++;
         if (out0 !== old_w63 || done !== 1'b0)
            $display("FAIL wait_pause i=%0d: got out0=%h done=%b expected out0=%h done=0", i, out0, done, old_w63);
         else n_pass++;
      end
      expect_range(0, 63, 1'b0);
   endtask

   task automatic test_running_gap();
      set_block(32'hBB67AE85);
      do_run(7'd0);
      expect_range(0, 20, 1'b0);
      running = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++;
         if (out0 !== w_exp[20] || done !== 1'b0)
            $display("FAIL gap i=%0d: got out0=%h done=%b expected out0=%h done=0", i, out0, done, w_exp[20]);
         else n_pass++;
      end
      running = 1'b1;
      expect_range(21, 63, 1'b0);
   endtask

   task automatic test_back_to_back();
      set_block(32'h510E527F);
      do_run(7'd0);
      expect_range(0, 63, 1'b0);
      expect_hold(2, w_exp[63]);
   endtask

   task automatic test_mid_rst();
      set_block(32'h1F83D9AB);
      do_run(7'd0);
      expect_range(0, 10, 1'b0);
      #2 rst = 1'b1;
      #1;
      n_total++;
      if (out0 !== 32'h0 || out1 !== 32'h0 || done !== 1'b1)
         $display("FAIL mid_rst: got out0=%h out1=%h done=%b expected 0/0/1", out0, out1, done);
      else n_pass++;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++;
         if (out0 !== 32'h0 || done !== 1'b1)
            $display("FAIL post_rst i=%0d: got out0=%h done=%b expected 0/1", i, out0, done);
         else n_pass++;
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      #1 rst = 1'b1;
      #2;
      test_reset();
      tick();
      tick();
      rst = 1'b0;
      test_reset();
      test_abc();
      test_delay();
      test_wait_pause();
      test_running_gap();
      test_back_to_back();
      test_mid_rst();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
